// File: rtl/regbank_arb_pkg.sv
// Shared types and constants for the register-bank arbiter.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package regbank_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_ACK    = 2'd2
  } arb_state_e;

  localparam int unsigned REQ_SPI = 0;
  localparam int unsigned REQ_I2C = 1;
  localparam int unsigned CNT_W   = 8;

  // Saturating increment; the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/regbank_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the other index.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
module rr_arbiter2
  import regbank_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o,
  output logic       grant_idx_o
);

  // Tie goes to the requester that did not win last time; otherwise the lone one.
  always_comb begin
    grant_idx_o = 1'b0;
    grant_o     = 2'b00;
    if (req_i == 2'b11) begin
      grant_idx_o = ~last_grant_i;
    end else begin
      grant_idx_o = req_i[REQ_I2C];
    end
    if (|req_i) begin
      grant_o = grant_idx_o ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/regbank_arbiter.sv
// Shares one register-bank port between SPI (req 0) and I2C (req 1), round-robin.
// Latency: req in IDLE cycle N -> bank strobe N+1 -> ack N+2; one access per 3 cycles.
// Backpressure: requests are held until ack; losers stay pending. Optional stats: REGBANK_ARB_STATS_EN.
module regbank_arbiter
  import regbank_arb_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int REG_W  = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [REG_W-1:0]  wdata0,
  input  logic [REG_W-1:0]  wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [REG_W-1:0]  rdata0,
  output logic [REG_W-1:0]  rdata1,
  output logic              bank_we,
  output logic              bank_re,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [REG_W-1:0]  bank_wdata,
  input  logic [REG_W-1:0]  bank_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  arb_state_e        state_q;
  logic              last_grant_q;
  logic              grant_idx_q;
  logic              bank_we_q;
  logic              bank_re_q;
  logic [ADDR_W-1:0] bank_addr_q;
  logic [REG_W-1:0]  bank_wdata_q;
  logic [REG_W-1:0]  rdata0_q;
  logic [REG_W-1:0]  rdata1_q;
  logic              ack0_q;
  logic              ack1_q;

  logic [1:0]        grant;
  logic              grant_idx;
  logic              win_we_d;
  logic [ADDR_W-1:0] win_addr_d;
  logic [REG_W-1:0]  win_wdata_d;

  rr_arbiter2 u_rr (
    .req_i        ({req1, req0}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx)
  );

  // Steer the winning requester's command onto the bank-side next-state values.
  always_comb begin
    win_we_d    = 1'b0;
    win_addr_d  = '0;
    win_wdata_d = '0;
    if (grant[REQ_I2C]) begin
      win_we_d    = we1;
      win_addr_d  = addr1;
      win_wdata_d = wdata1;
    end else if (grant[REQ_SPI]) begin
      win_we_d    = we0;
      win_addr_d  = addr0;
      win_wdata_d = wdata0;
    end
  end

  // Arbitration FSM with all bank strobes, acks and read data registered.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
      grant_idx_q  <= 1'b0;
      bank_we_q    <= 1'b0;
      bank_re_q    <= 1'b0;
      bank_addr_q  <= '0;
      bank_wdata_q <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (ena && (req0 || req1)) begin
            grant_idx_q  <= grant_idx;
            last_grant_q <= grant_idx;
            bank_addr_q  <= win_addr_d;
            bank_wdata_q <= win_wdata_d;
            bank_we_q    <= win_we_d;
            bank_re_q    <= ~win_we_d;
            state_q      <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          // Bank read data is combinational from bank_addr, so it is valid now.
          if (bank_re_q) begin
            if (grant_idx_q) rdata1_q <= bank_rdata;
            else             rdata0_q <= bank_rdata;
          end
          bank_we_q <= 1'b0;
          bank_re_q <= 1'b0;
          ack0_q    <= ~grant_idx_q;
          ack1_q    <= grant_idx_q;
          state_q   <= ARB_ACK;
        end
        ARB_ACK: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          state_q <= ARB_IDLE;
        end
        default: begin
          bank_we_q <= 1'b0;
          bank_re_q <= 1'b0;
          ack0_q    <= 1'b0;
          ack1_q    <= 1'b0;
          state_q   <= ARB_IDLE;
        end
      endcase
    end
  end

`ifdef REGBANK_ARB_STATS_EN
  logic [CNT_W-1:0] conflict_cnt_q;

  // Count idle cycles where both front ends contend for the bank; saturating.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      conflict_cnt_q <= '0;
    end else if ((state_q == ARB_IDLE) && ena && req0 && req1) begin
      conflict_cnt_q <= sat_inc(conflict_cnt_q);
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`else
  assign conflict_cnt = '0;
`endif

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign bank_we    = bank_we_q;
  assign bank_re    = bank_re_q;
  assign bank_addr  = bank_addr_q;
  assign bank_wdata = bank_wdata_q;

endmodule
